// File: rtl/rif_csr_bank_if.sv
// rif_csr_bank_if: RIF request/response bundle between the AXI4-Lite adapter and the CSR bank.
interface rif_csr_bank_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   rif_waddr;
    logic                    rif_wr_req;
    logic [DATA_WIDTH/8-1:0] rif_wstrb;
    logic [DATA_WIDTH-1:0]   rif_wdata;
    logic                    rif_wvalid;
    logic [ADDR_WIDTH-1:0]   rif_raddr;
    logic                    rif_rd_req;
    logic [DATA_WIDTH-1:0]   rif_rdata;
    logic                    rif_rvalid;

    modport master (
        output rif_waddr, rif_wr_req, rif_wstrb, rif_wdata, rif_raddr, rif_rd_req,
        input  rif_wvalid, rif_rdata, rif_rvalid
    );

    modport slave (
        input  rif_waddr, rif_wr_req, rif_wstrb, rif_wdata, rif_raddr, rif_rd_req,
        output rif_wvalid, rif_rdata, rif_rvalid
    );
endinterface

// File: rtl/rif_csr_bank.sv
// rif_csr_bank: CSR map behind the RIF port with ID/CTRL, status mirror, W1C interrupts
// and a 64-bit cycle counter whose HI word is latched by every CNT_LO read.
module rif_csr_bank #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter int          N_IRQ      = 8,
    parameter logic [31:0] ID_VALUE   = 32'h0000_0001,
    parameter logic [31:0] CTRL_RESET = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    rif_csr_bank_if.slave         rif,
    input  logic [DATA_WIDTH-1:0] hw_status,
    input  logic [N_IRQ-1:0]      irq_event,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    output logic                  irq
);
    if (DATA_WIDTH != 32) begin : g_dw_chk
        $fatal(1, "rif_csr_bank: DATA_WIDTH must be 32");
    end
    if (N_IRQ < 1 || N_IRQ > 32) begin : g_irq_chk
        $fatal(1, "rif_csr_bank: N_IRQ must be 1..32");
    end
    if (ADDR_WIDTH < 9) begin : g_aw_chk
        $fatal(1, "rif_csr_bank: ADDR_WIDTH must be at least 9");
    end

    logic [31:0]      r_ctrl;
    logic [N_IRQ-1:0] r_st;
    logic [N_IRQ-1:0] r_mask;
    logic [63:0]      r_cnt;
    logic [31:0]      r_shadow;
    logic             r_en;
    logic             r_irq;

    logic             w_rok, w_wok;
    logic [5:0]       w_ridx, w_widx;
    logic             w_wr_ctrl, w_wr_st, w_wr_mask, w_wr_set, w_wr_cc;
    logic [31:0]      w_bmask;
    logic [N_IRQ-1:0] w_m, w_d, w_st_next, w_mask_next;
    logic             w_clr, w_en_next, w_cap;

    // Anything above byte 0xFF or not word aligned is rejected outright.
    assign w_rok  = rif.rif_raddr[ADDR_WIDTH-1:8] == '0 && rif.rif_raddr[1:0] == 2'b00;
    assign w_wok  = rif.rif_waddr[ADDR_WIDTH-1:8] == '0 && rif.rif_waddr[1:0] == 2'b00;
    assign w_ridx = rif.rif_raddr[7:2];
    assign w_widx = rif.rif_waddr[7:2];

    always_comb begin
        rif.rif_rdata  = '0;
        rif.rif_rvalid = w_rok;
        if (w_rok) begin
            case (w_ridx)
                6'd0:    rif.rif_rdata = ID_VALUE;
                6'd1:    rif.rif_rdata = r_ctrl;
                6'd2:    rif.rif_rdata = hw_status;
                6'd3:    rif.rif_rdata = 32'(r_st);
                6'd4:    rif.rif_rdata = 32'(r_mask);
                6'd5:    rif.rif_rdata = '0;
                6'd6:    rif.rif_rdata = r_cnt[31:0];
                6'd7:    rif.rif_rdata = r_shadow;
                6'd8:    rif.rif_rdata = {31'b0, r_en};
                default: rif.rif_rvalid = 1'b0;
            endcase
        end
    end

    assign w_wr_ctrl      = w_wok && w_widx == 6'd1;
    assign w_wr_st        = w_wok && w_widx == 6'd3;
    assign w_wr_mask      = w_wok && w_widx == 6'd4;
    assign w_wr_set       = w_wok && w_widx == 6'd5;
    assign w_wr_cc        = w_wok && w_widx == 6'd8;
    assign rif.rif_wvalid = w_wr_ctrl | w_wr_st | w_wr_mask | w_wr_set | w_wr_cc;

    assign w_bmask = {{8{rif.rif_wstrb[3]}}, {8{rif.rif_wstrb[2]}},
                      {8{rif.rif_wstrb[1]}}, {8{rif.rif_wstrb[0]}}};
    assign w_m     = w_bmask[N_IRQ-1:0];
    assign w_d     = rif.rif_wdata[N_IRQ-1:0] & w_m;

    // Sets are OR-ed in after the clear so a same-cycle event always wins.
    assign w_st_next   = (r_st & ~((rif.rif_wr_req && w_wr_st) ? w_d : '0)) | irq_event
                         | ((rif.rif_wr_req && w_wr_set) ? w_d : '0);
    assign w_mask_next = (rif.rif_wr_req && w_wr_mask) ? ((r_mask & ~w_m) | w_d) : r_mask;
    assign w_clr       = rif.rif_wr_req && w_wr_cc && rif.rif_wstrb[0] && rif.rif_wdata[1];
    assign w_en_next   = (rif.rif_wr_req && w_wr_cc && rif.rif_wstrb[0]) ? rif.rif_wdata[0] : r_en;
    assign w_cap       = rif.rif_rd_req && w_rok && w_ridx == 6'd6;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= CTRL_RESET;
            r_st     <= '0;
            r_mask   <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_en     <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (rif.rif_wr_req && w_wr_ctrl) r_ctrl <= (r_ctrl & ~w_bmask) | (rif.rif_wdata & w_bmask);
            if (w_cap) r_shadow <= r_cnt[63:32];
            r_st  <= w_st_next;
            r_mask <= w_mask_next;
            r_cnt <= w_clr ? 64'd0 : r_cnt + 64'(r_en);
            r_en  <= w_en_next;
            r_irq <= |(w_st_next & w_mask_next);
        end
    end

    assign ctrl_out = r_ctrl;
    assign irq      = r_irq;
endmodule

// File: tb/tb_rif_csr_bank.sv
// tb_rif_csr_bank: directed RIF accesses; expectations are queued per cycle and checked by
// an independent monitor on the falling edge.
module tb_rif_csr_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] hw_status = '0;
    logic [7:0]  irq_event = '0;
    logic [31:0] ctrl_out;
    logic        irq;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic        v;
        logic [31:0] d;
    } exp_t;
    exp_t q[$];

    rif_csr_bank_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) rif_bus ();

    rif_csr_bank dut (
        .clk       (clk),
        .reset     (reset),
        .rif       (rif_bus.slave),
        .hw_status (hw_status),
        .irq_event (irq_event),
        .ctrl_out  (ctrl_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 read {rvalid,rdata}, 1 wvalid, 2 irq, 3 ctrl_out
    function automatic void ex(int k, string n, logic v, logic [31:0] d);
        q.push_back('{cyc, k, n, v, d});
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (e.kind == 0) begin
                if (rif_bus.rif_rd_req !== 1'b1 || rif_bus.rif_rvalid !== e.v || rif_bus.rif_rdata !== e.d) begin
                    n_fail++;
                    $display("FAIL %s: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                             e.name, rif_bus.rif_rvalid, rif_bus.rif_rdata, e.v, e.d);
                end
            end else if (e.kind == 1) begin
                if (rif_bus.rif_wr_req !== 1'b1 || rif_bus.rif_wvalid !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got wvalid=%b, want %b", e.name, rif_bus.rif_wvalid, e.v);
                end
            end else if (e.kind == 2) begin
                if (irq !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got irq=%b, want %b", e.name, irq, e.v);
                end
            end else begin
                if (ctrl_out !== e.d) begin
                    n_fail++;
                    $display("FAIL %s: got ctrl_out=%h, want %h", e.name, ctrl_out, e.d);
                end
            end
        end
    end

    task automatic drive(input bit rs, input bit wr, input logic [11:0] wa, input logic [3:0] ws,
                         input logic [31:0] wd, input bit rd, input logic [11:0] ra, input logic [7:0] ev);
        @(posedge clk);
        #1;
        reset              = rs;
        rif_bus.rif_wr_req = wr;
        rif_bus.rif_waddr  = wa;
        rif_bus.rif_wstrb  = ws;
        rif_bus.rif_wdata  = wd;
        rif_bus.rif_rd_req = rd;
        rif_bus.rif_raddr  = ra;
        irq_event          = ev;
    endtask

    initial begin
        rif_bus.rif_wr_req = 1'b0;
        rif_bus.rif_rd_req = 1'b0;
        rif_bus.rif_waddr  = '0;
        rif_bus.rif_raddr  = '0;
        rif_bus.rif_wstrb  = '0;
        rif_bus.rif_wdata  = '0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 12'h000, 0);
        ex(0, "id", 1, 32'h0000_0001); ex(2, "irq_rst", 0, 0); ex(3, "ctrl_rst", 0, 32'h0);
        drive(0, 1, 12'h004, 4'b0101, 32'hA5A5_5A5A, 1, 12'h004, 0);
        ex(1, "ctrl_wr", 1, 0); ex(0, "ctrl_pre", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 12'h004, 0);
        ex(0, "ctrl_rd", 1, 32'h00A5_005A); ex(3, "ctrl_out", 0, 32'h00A5_005A);
        drive(0, 1, 12'h008, 4'hF, 32'h1234_5678, 1, 12'h024, 0);
        ex(1, "wr_ro_status", 0, 0); ex(0, "rd_unmapped", 0, 0);
        drive(0, 1, 12'h014, 4'hF, 32'h0, 1, 12'h00E, 0);
        ex(1, "wr_irqset_zero", 1, 0); ex(0, "rd_unaligned", 0, 0);
        drive(0, 1, 12'h104, 4'hF, 32'hFFFF_FFFF, 1, 12'h014, 0);
        ex(1, "wr_upper_bits", 0, 0); ex(0, "rd_irqset", 1, 0);
        drive(0, 1, 12'h010, 4'b0001, 32'h1, 1, 12'h004, 0);
        ex(1, "mask_wr", 1, 0); ex(0, "ctrl_unchanged", 1, 32'h00A5_005A);
        drive(0, 0, 0, 0, 0, 1, 12'h00C, 8'h01);
        ex(0, "irqst_pre_ev", 1, 0); ex(2, "irq_pre_ev", 0, 0);
        drive(0, 1, 12'h00C, 4'b0001, 32'h1, 1, 12'h00C, 8'h01);
        ex(2, "irq_after_ev", 1, 0); ex(0, "irqst_set", 1, 32'h1); ex(1, "w1c_wr", 1, 0);
        drive(0, 1, 12'h00C, 4'b0000, 32'h1, 1, 12'h00C, 0);
        ex(2, "irq_set_beats_clr", 1, 0); ex(0, "irqst_set_beats_clr", 1, 32'h1); ex(1, "w1c_nostrb", 1, 0);
        drive(0, 1, 12'h00C, 4'b0001, 32'h1, 1, 12'h00C, 0);
        ex(2, "irq_nostrb", 1, 0); ex(0, "irqst_nostrb", 1, 32'h1);
        drive(0, 0, 0, 0, 0, 1, 12'h00C, 0);
        ex(2, "irq_cleared", 0, 0); ex(0, "irqst_cleared", 1, 32'h0);
        drive(0, 1, 12'h014, 4'b0001, 32'h80, 1, 12'h010, 0);
        ex(0, "mask_rd", 1, 32'h1);
        drive(0, 1, 12'h010, 4'b0001, 32'h81, 1, 12'h00C, 0);
        ex(0, "irqset_status", 1, 32'h80); ex(2, "irq_masked", 0, 0);
        drive(0, 1, 12'h00C, 4'hF, 32'hFFFF_FFFF, 1, 12'h010, 0);
        ex(2, "irq_unmasked", 1, 0); ex(0, "mask_81", 1, 32'h81);
        hw_status = 32'hDEAD_BEEF;
        drive(0, 0, 0, 0, 0, 1, 12'h008, 0);
        ex(2, "irq_w1c_all", 0, 0); ex(0, "status_mirror", 1, 32'hDEAD_BEEF);
        drive(0, 1, 12'h020, 4'b0001, 32'h3, 1, 12'h020, 0);
        ex(1, "cnt_clr_en", 1, 0); ex(0, "cntctrl_pre", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 12'h018, 0);
        ex(0, "cnt_after_clr", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 12'h018, 0);
        ex(0, "cnt_inc", 1, 32'h1);
        drive(0, 0, 0, 0, 0, 1, 12'h020, 0);
        ex(0, "cntctrl_en", 1, 32'h1);
        drive(0, 1, 12'h018, 4'hF, 32'h0, 1, 12'h018, 0);
        ex(0, "cnt_3", 1, 32'h3); ex(1, "wr_ro_cnt", 0, 0);
        drive(0, 0, 0, 0, 0, 1, 12'h018, 0);
        force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
        ex(0, "cnt_lo_ffff", 1, 32'hFFFF_FFFF);
        #5 release dut.r_cnt;
        drive(0, 0, 0, 0, 0, 1, 12'h01C, 0);
        ex(0, "cnt_hi_coherent", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 12'h018, 0);
        ex(0, "cnt_lo_carry", 1, 32'h1);
        drive(0, 0, 0, 0, 0, 1, 12'h01C, 0);
        ex(0, "cnt_hi_carry", 1, 32'h1);
        drive(0, 1, 12'h014, 4'b0001, 32'h1, 0, 0, 0);
        drive(1, 1, 12'h004, 4'hF, 32'hFFFF_FFFF, 0, 0, 8'h01);
        ex(2, "irq_before_rst", 1, 0);
        drive(0, 0, 0, 0, 0, 1, 12'h004, 0);
        ex(2, "irq_after_rst", 0, 0); ex(3, "ctrl_out_rst", 0, 32'h0); ex(0, "ctrl_rst_rd", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 12'h00C, 0);
        ex(0, "irqst_rst_ev_dropped", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 12'h010, 0);
        ex(0, "mask_rst", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 12'h018, 0);
        ex(0, "cnt_rst_stopped", 1, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #5;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
